fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, holds the fetched word until decode
// accepts it, and squashes in-flight or held work on a taken branch.
module fetch_unit #(
  parameter int AW = 8,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          stall,
  output logic          if_valid,
  output logic [IW-1:0] if_instr,
  output logic [3:0]    if_opcode,
  output logic [AW-1:0] if_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [AW-1:0]   ipc_q, ipc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    case (state_q)
      IDLE: begin
        // A redirect here is folded into the very first request.
        pc_d    = br_taken ? br_target : pc_q;
        addr_d  = br_taken ? br_target : pc_q;
        req_d   = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        if (br_taken) begin
          pc_d = br_target;
          if (imem_ack) begin
            addr_d = br_target;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = addr_q;
          valid_d = 1'b1;
          pc_d    = pc_q + AW'(1);
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (br_taken) begin
          valid_d = 1'b0;
          pc_d    = br_target;
          addr_d  = br_target;
          req_d   = 1'b1;
          state_d = FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          addr_d  = pc_q;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // The stale request must complete before the redirected one is issued.
        if (br_taken) begin
          pc_d = br_target;
        end
        if (imem_ack) begin
          addr_d  = br_taken ? br_target : pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_opcode = instr_q[IW-1:IW-4];
  assign if_pc     = ipc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: each vector is driven before an edge and the
// registered outputs are compared just after it.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        stall;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [3:0]  if_opcode;
  logic [7:0]  if_pc;

  int n_pass;
  int n_total;

  fetch_unit #(.AW(8), .IW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .stall      (stall),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_opcode  (if_opcode),
    .if_pc      (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       ack;
    logic [15:0] rdata;
    logic       br;
    logic [7:0] tgt;
    logic       stall;
    logic       e_req;
    logic [7:0] e_addr;
    logic       e_valid;
    logic [15:0] e_instr;
    logic [7:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic a, logic [15:0] d, logic b,
                              logic [7:0] t, logic s, logic er, logic [7:0] ea,
                              logic ev, logic [15:0] ei, logic [7:0] ep);
    vec_t v;
    v.name = name; v.rst = r; v.ack = a; v.rdata = d; v.br = b; v.tgt = t; v.stall = s;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
    return v;
  endfunction

  task automatic step(input vec_t v);
    logic [3:0]  e_op;
    logic [44:0] act, exp;
    @(negedge clk);
    rst        = v.rst;
    imem_ack   = v.ack;
    imem_rdata = v.rdata;
    br_taken   = v.br;
    br_target  = v.tgt;
    stall      = v.stall;
    @(posedge clk);
    #1;
    e_op = v.e_instr[15:12];
    act  = {imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc};
    exp  = {v.e_req, v.e_addr, v.e_valid, v.e_instr, e_op, v.e_pc};
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h op=%h pc=%h, want req=%b addr=%h valid=%b instr=%h op=%h pc=%h",
               v.name, imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc,
               v.e_req, v.e_addr, v.e_valid, v.e_instr, e_op, v.e_pc);
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; br_taken = 1'b0; br_target = '0; stall = 1'b0;

    //                 name           rst ack rdata     br tgt    st   req addr   vld instr     pc
    vecs.push_back(mk("reset",         1, 0, 16'h0000, 0, 8'h00, 0,   0, 8'h00, 0, 16'h0000, 8'h00));
    vecs.push_back(mk("first_req",     0, 1, 16'h1234, 0, 8'h00, 0,   1, 8'h00, 0, 16'h0000, 8'h00));
    vecs.push_back(mk("first_cap",     0, 1, 16'h1234, 0, 8'h00, 0,   0, 8'h00, 1, 16'h1234, 8'h00));
    vecs.push_back(mk("second_req",    0, 1, 16'h1234, 0, 8'h00, 0,   1, 8'h01, 0, 16'h1234, 8'h00));
    vecs.push_back(mk("second_cap",    0, 1, 16'hA001, 0, 8'h00, 0,   0, 8'h01, 1, 16'hA001, 8'h01));
    vecs.push_back(mk("stall_1",       0, 1, 16'h5555, 0, 8'h00, 1,   0, 8'h01, 1, 16'hA001, 8'h01));
    vecs.push_back(mk("stall_2",       0, 1, 16'h6666, 0, 8'h00, 1,   0, 8'h01, 1, 16'hA001, 8'h01));
    vecs.push_back(mk("stall_3",       0, 0, 16'h7777, 0, 8'h00, 1,   0, 8'h01, 1, 16'hA001, 8'h01));
    vecs.push_back(mk("stall_4",       0, 1, 16'h8888, 0, 8'h00, 1,   0, 8'h01, 1, 16'hA001, 8'h01));
    vecs.push_back(mk("stall_5",       0, 1, 16'h9999, 0, 8'h00, 1,   0, 8'h01, 1, 16'hA001, 8'h01));
    vecs.push_back(mk("unstall",       0, 0, 16'h0000, 0, 8'h00, 0,   1, 8'h02, 0, 16'hA001, 8'h01));
    vecs.push_back(mk("cap_b0b0",      0, 1, 16'hB0B0, 0, 8'h00, 0,   0, 8'h02, 1, 16'hB0B0, 8'h02));
    vecs.push_back(mk("br_in_hold",    0, 1, 16'h0000, 1, 8'h10, 1,   1, 8'h10, 0, 16'hB0B0, 8'h02));
    vecs.push_back(mk("br_fetch_ack",  0, 1, 16'h7777, 1, 8'h20, 0,   1, 8'h20, 0, 16'hB0B0, 8'h02));
    vecs.push_back(mk("br_to_05",      0, 1, 16'h7777, 1, 8'h05, 0,   1, 8'h05, 0, 16'hB0B0, 8'h02));
    vecs.push_back(mk("wait_05",       0, 0, 16'h0000, 0, 8'h00, 0,   1, 8'h05, 0, 16'hB0B0, 8'h02));
    vecs.push_back(mk("br_to_drain",   0, 0, 16'h0000, 1, 8'h40, 0,   1, 8'h05, 0, 16'hB0B0, 8'h02));
    vecs.push_back(mk("drain_wait",    0, 0, 16'h0000, 0, 8'h00, 0,   1, 8'h05, 0, 16'hB0B0, 8'h02));
    vecs.push_back(mk("drain_ack",     0, 1, 16'hFFFF, 0, 8'h00, 0,   1, 8'h40, 0, 16'hB0B0, 8'h02));
    vecs.push_back(mk("cap_at_40",     0, 1, 16'hC123, 0, 8'h00, 0,   0, 8'h40, 1, 16'hC123, 8'h40));
    vecs.push_back(mk("after_40",      0, 0, 16'h0000, 0, 8'h00, 0,   1, 8'h41, 0, 16'hC123, 8'h40));
    vecs.push_back(mk("reset_2",       1, 1, 16'h4444, 0, 8'h00, 0,   0, 8'h00, 0, 16'h0000, 8'h00));
    vecs.push_back(mk("br_in_idle",    0, 0, 16'h0000, 1, 8'h33, 0,   1, 8'h33, 0, 16'h0000, 8'h00));
    vecs.push_back(mk("cap_at_33",     0, 1, 16'h2345, 0, 8'h00, 0,   0, 8'h33, 1, 16'h2345, 8'h33));

    foreach (vecs[i]) step(vecs[i]);

    // Program counter wrap at the top of the address space.
    step(mk("wrap_reset",  1, 0, 16'h0000, 0, 8'h00, 0,   0, 8'h00, 0, 16'h0000, 8'h00));
    step(mk("wrap_req_ff", 0, 0, 16'h0000, 1, 8'hFF, 0,   1, 8'hFF, 0, 16'h0000, 8'h00));
    step(mk("wrap_cap_ff", 0, 1, 16'h9ABC, 0, 8'h00, 0,   0, 8'hFF, 1, 16'h9ABC, 8'hFF));
    step(mk("wrap_req_00", 0, 0, 16'h0000, 0, 8'h00, 0,   1, 8'h00, 0, 16'h9ABC, 8'hFF));

    // Reset landing on the same edge as an ack abandons the request.
    step(mk("rst_mid_req", 1, 1, 16'hDEAD, 0, 8'h00, 0,   0, 8'h00, 0, 16'h0000, 8'h00));
    step(mk("post_rst_ack",0, 1, 16'hBEEF, 0, 8'h00, 0,   1, 8'h00, 0, 16'h0000, 8'h00));
    step(mk("post_rst_cap",0, 1, 16'h3210, 0, 8'h00, 0,   0, 8'h00, 1, 16'h3210, 8'h00));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
